complex_divider: RTL

Sequential divider for the packed 5+5-bit signed complex operand format used by the complex ALU: computes op_A / op_B = ((ac+bd) + (bc−ad)i) / (c²+d²) by restoring division, one quotient bit per cycle. It is the inverse operation to the ALU's combinational multiplier. It returns its result in the ALU's 22-bit result layout, so downstream logic handles both blocks the same way.

---
 rtl/complex_divider_if.sv | 22 ++
 rtl/complex_divider.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/complex_divider_if.sv
// complex_divider_if: request/response bundle for the complex divider.
//   start        request, sampled only while the divider is idle
//   op_A, op_B   packed 5+5-bit signed complex operands {real, imag}
//   busy         divider is working on an operation
//   done         one-cycle pulse when result/div_by_zero update
//   result       {real quotient[10:0], imag quotient[10:0]}, both signed
//   div_by_zero  last operation had a zero divisor
// master drives requests (the client), slave is the divider.
interface complex_divider_if;
  logic        start;
  logic [9:0]  op_A;
  logic [9:0]  op_B;
  logic        busy;
  logic        done;
  logic [21:0] result;
  logic        div_by_zero;

  modport master (output start, op_A, op_B,
                  input  busy, done, result, div_by_zero);
  modport slave  (input  start, op_A, op_B,
                  output busy, done, result, div_by_zero);
endinterface

// File: rtl/complex_divider.sv
// complex_divider: sequential complex division op_A / op_B
//   = ((ac+bd) + (bc-ad)i) / (c^2+d^2), restoring division, one quotient
//   bit per cycle for the real and imaginary lanes in parallel.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    complex_divider_if.slave (start/op_A/op_B in, busy/done/result/
//          div_by_zero out)
// Latency: start -> PREP -> 10 x DIV -> FIN; done pulses the cycle after FIN.
// A zero divisor skips DIV and reports div_by_zero with result = 0.

// One restoring-division lane: |num| / den, MSB first, bit index cnt.
module complex_divider_lane (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       step,
  input  logic [3:0] cnt,
  input  logic [9:0] num,
  input  logic [9:0] den,
  output logic [9:0] quo
);
  logic [10:0] rem, rem_sh, rem_nxt;
  logic        ge;

  always_comb begin
    rem_sh  = {rem[9:0], num[cnt]};
    // a set rem[10] would be shifted out; it still means the value is >= den
    ge      = rem[10] | (rem_sh >= {1'b0, den});
    rem_nxt = ge ? (rem_sh - {1'b0, den}) : rem_sh;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem <= '0;
      quo <= '0;
    end else if (clr) begin
      rem <= '0;
      quo <= '0;
    end else if (step) begin
      rem      <= rem_nxt;
      quo[cnt] <= ge;
    end
  end
endmodule

module complex_divider (
  input  logic             clk,
  input  logic             rst_n,
  complex_divider_if.slave bus
);
  localparam int NUM_LANES = 2;  // lane 0 = real, lane 1 = imaginary

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PREP = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_FIN  = 2'd3;

  logic [1:0]  state;
  logic [9:0]  opa_r, opb_r;
  logic [9:0]  den;
  logic [3:0]  cnt;
  logic        zf;
  logic [NUM_LANES-1:0][9:0]  mag, quo;
  logic [NUM_LANES-1:0][10:0] q11;
  logic [NUM_LANES-1:0]       neg;
  logic        done_r, dbz_r;
  logic [21:0] res_r;

  // operand expansion and numerator/denominator for PREP
  logic signed [10:0] a_e, b_e, c_e, d_e, nr_c, ni_c;
  logic [4:0]  c_m, d_m;
  logic [9:0]  den_c;

  always_comb begin
    a_e   = {{6{opa_r[9]}}, opa_r[9:5]};
    b_e   = {{6{opa_r[4]}}, opa_r[4:0]};
    c_e   = {{6{opb_r[9]}}, opb_r[9:5]};
    d_e   = {{6{opb_r[4]}}, opb_r[4:0]};
    nr_c  = a_e * c_e + b_e * d_e;
    ni_c  = b_e * c_e - a_e * d_e;
    // squares from magnitudes keep den unsigned; |-16| = 16 fits 5 bits
    c_m   = opb_r[9] ? (~opb_r[9:5] + 5'd1) : opb_r[9:5];
    d_m   = opb_r[4] ? (~opb_r[4:0] + 5'd1) : opb_r[4:0];
    den_c = {5'd0, c_m} * {5'd0, c_m} + {5'd0, d_m} * {5'd0, d_m};
  end

  // |v| never exceeds 512, so the low 10 bits carry the whole magnitude
  function automatic logic [9:0] abs10(input logic signed [10:0] v);
    return v[10] ? (~v[9:0] + 10'd1) : v[9:0];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      opa_r  <= '0;
      opb_r  <= '0;
      mag    <= '0;
      neg    <= '0;
      den    <= '0;
      cnt    <= '0;
      zf     <= 1'b0;
      res_r  <= '0;
      dbz_r  <= 1'b0;
      done_r <= 1'b0;
    end else begin
      done_r <= (state == S_FIN);
      case (state)
        S_IDLE: if (bus.start) begin
          opa_r <= bus.op_A;
          opb_r <= bus.op_B;
          state <= S_PREP;
        end
        S_PREP: begin
          mag[0] <= abs10(nr_c);
          mag[1] <= abs10(ni_c);
          neg    <= {ni_c[10], nr_c[10]};
          den    <= den_c;
          zf     <= (den_c == 10'd0);
          cnt    <= 4'd9;
          state  <= (den_c == 10'd0) ? S_FIN : S_DIV;
        end
        S_DIV: begin
          if (cnt == 4'd0) state <= S_FIN;
          else             cnt   <= cnt - 4'd1;
        end
        default: begin  // S_FIN
          res_r <= zf ? 22'd0 : {q11[0], q11[1]};
          dbz_r <= zf;
          state <= S_IDLE;
        end
      endcase
    end
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    logic [9:0] qn;
    complex_divider_lane u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (state == S_PREP),
      .step  (state == S_DIV),
      .cnt   (cnt),
      .num   (mag[l]),
      .den   (den),
      .quo   (quo[l])
    );
    // sign applied after the magnitude divide gives truncation toward zero
    assign qn     = neg[l] ? (~quo[l] + 10'd1) : quo[l];
    assign q11[l] = {qn[9], qn};
  end

  assign bus.busy        = (state != S_IDLE);
  assign bus.done        = done_r;
  assign bus.result      = res_r;
  assign bus.div_by_zero = dbz_r;
endmodule
